// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external combinational ALU between two requesters,
// with a single registered response slot tagged to the winning requester.
module alu_share_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid0,
   input  logic        req_valid1,
   output logic        req_ready0,
   output logic        req_ready1,
   input  logic [3:0]  req_op0,
   input  logic [3:0]  req_op1,
   input  logic [31:0] req_a0,
   input  logic [31:0] req_a1,
   input  logic [31:0] req_b0,
   input  logic [31:0] req_b1,
   output logic [3:0]  alu_ctrl,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic [31:0] alu_result,
   input  logic        alu_zero,
   output logic        rsp_valid0,
   output logic        rsp_valid1,
   input  logic        rsp_ready0,
   input  logic        rsp_ready1,
   output logic [31:0] rsp_data,
   output logic        rsp_zero,
   output logic        rsp_err
);

   logic full;
   logic owner;
   logic prio;
   logic pop;
   logic slot_free;
   logic grant0;
   logic grant1;
   logic illegal;

   // Handshake: a request transfers in a cycle where req_valid_i and req_ready_i
   // are both high; a response transfers where rsp_valid_i and rsp_ready_i are high.
   assign pop       = full && (owner ? rsp_ready1 : rsp_ready0);
   assign slot_free = !full || pop;

   // Ready is forced low during reset so nothing is accepted while the slot is cleared.
   assign grant0 = !rst && slot_free && req_valid0 && (!req_valid1 || !prio);
   assign grant1 = !rst && slot_free && req_valid1 && (!req_valid0 || prio);

   assign req_ready0 = grant0;
   assign req_ready1 = grant1;

   always_comb begin
      alu_ctrl = 4'b0000;
      alu_a    = '0;
      alu_b    = '0;
      if (grant0) begin
         alu_ctrl = req_op0;
         alu_a    = req_a0;
         alu_b    = req_b0;
      end else if (grant1) begin
         alu_ctrl = req_op1;
         alu_a    = req_a1;
         alu_b    = req_b1;
      end
   end

   // Codes 0101 and 1111 have no ALU meaning; their ALU output is never sampled.
   assign illegal = (alu_ctrl == 4'b0101) || (alu_ctrl == 4'b1111);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full     <= 1'b0;
         owner    <= 1'b0;
         prio     <= 1'b0;
         rsp_data <= '0;
         rsp_zero <= 1'b0;
         rsp_err  <= 1'b0;
      end else if (grant0 || grant1) begin
         full     <= 1'b1;
         owner    <= grant1;
         prio     <= !grant1;
         rsp_data <= illegal ? 32'd0 : alu_result;
         rsp_zero <= illegal ? 1'b1 : alu_zero;
         rsp_err  <= illegal;
      end else if (pop) begin
         full <= 1'b0;
      end
   end

   assign rsp_valid0 = full && !owner;
   assign rsp_valid1 = full && owner;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and random stimulus for alu_share_arbiter with a behavioural ALU
// attached and a queue of expected responses.
module tb_alu_share_arbiter;

   logic        clk;
   logic        rst;
   logic        req_valid0, req_valid1;
   logic        req_ready0, req_ready1;
   logic [3:0]  req_op0, req_op1;
   logic [31:0] req_a0, req_a1, req_b0, req_b1;
   logic [3:0]  alu_ctrl;
   logic [31:0] alu_a, alu_b;
   logic [31:0] alu_result;
   logic        alu_zero;
   logic        rsp_valid0, rsp_valid1;
   logic        rsp_ready0, rsp_ready1;
   logic [31:0] rsp_data;
   logic        rsp_zero;
   logic        rsp_err;

   int vectors = 0;
   int miscompares = 0;

   logic [33:0] exp_q[$];
   logic [33:0] slot;
   logic        m_full, m_owner, m_prio;
   logic        last_g0, last_g1;

   localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010,
      OP_SUB = 4'b0110, OP_XOR = 4'b1010, OP_NOR = 4'b1100, OP_SRA = 4'b1101,
      OP_LUI = 4'b1110;

   alu_share_arbiter dut (
      .clk(clk), .rst(rst),
      .req_valid0(req_valid0), .req_valid1(req_valid1),
      .req_ready0(req_ready0), .req_ready1(req_ready1),
      .req_op0(req_op0), .req_op1(req_op1),
      .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
      .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
      .rsp_ready0(rsp_ready0), .rsp_ready1(rsp_ready1),
      .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0011: return b << a[4:0];
         4'b0100: return b >> a[4:0];
         4'b0110: return a - b;
         4'b0111: return {31'd0, $signed(a) < $signed(b)};
         4'b1000: return a + b;
         4'b1001: return a - b;
         4'b1010: return a ^ b;
         4'b1011: return {31'd0, a < b};
         4'b1100: return ~(a | b);
         4'b1101: return $signed(b) >>> a[4:0];
         4'b1110: return b << 16;
         default: return 'x;
      endcase
   endfunction

   always_comb begin
      alu_result = alu_fn(alu_ctrl, alu_a, alu_b);
      alu_zero   = (alu_result == 32'd0);
   end

   // Expected response word: {err, zero, data}
   function automatic logic [33:0] exp_rsp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      if (op == 4'b0101 || op == 4'b1111) return {1'b1, 1'b1, 32'd0};
      r = alu_fn(op, a, b);
      return {1'b0, r == 32'd0, r};
   endfunction

   task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_full  = 1'b0;
      m_owner = 1'b0;
      m_prio  = 1'b0;
      slot    = '0;
      exp_q.delete();
   endtask

   // Driver: called just after a falling edge, returns at the next falling edge.
   task automatic cycle(input logic v0, input logic v1,
                        input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                        input logic rr0, input logic rr1);
      logic pop, free, eg0, eg1;
      req_valid0 = v0;  req_valid1 = v1;
      req_op0 = op0;    req_a0 = a0;  req_b0 = b0;
      req_op1 = op1;    req_a1 = a1;  req_b1 = b1;
      rsp_ready0 = rr0; rsp_ready1 = rr1;
      pop  = m_full && (m_owner ? rr1 : rr0);
      free = !m_full || pop;
      eg0  = free && v0 && (!v1 || !m_prio);
      eg1  = free && v1 && (!v0 || m_prio);
      if (eg0) exp_q.push_back(exp_rsp(op0, a0, b0));
      if (eg1) exp_q.push_back(exp_rsp(op1, a1, b1));
      #4;
      last_g0 = req_ready0;
      last_g1 = req_ready1;
      chk("req_ready", {66'd0, req_ready0, req_ready1}, {66'd0, eg0, eg1});
      if (eg0)      chk("alu_drive", {alu_ctrl, alu_a, alu_b}, {op0, a0, b0});
      else if (eg1) chk("alu_drive", {alu_ctrl, alu_a, alu_b}, {op1, a1, b1});
      else          chk("alu_idle", {alu_ctrl, alu_a, alu_b}, 68'd0);
      @(posedge clk);
      #1;
      if (eg0 || eg1) begin
         m_full  = 1'b1;
         m_owner = eg1;
         m_prio  = !eg1;
         slot    = exp_q.pop_front();
      end else if (pop) begin
         m_full = 1'b0;
      end
      chk("rsp_valid", {66'd0, rsp_valid0, rsp_valid1}, {66'd0, m_full && !m_owner, m_full && m_owner});
      chk("rsp_payload", {34'd0, rsp_err, rsp_zero, rsp_data}, {34'd0, slot});
      @(negedge clk);
   endtask

   task automatic idle(input logic rr0, input logic rr1);
      cycle(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, rr0, rr1);
   endtask

   initial begin
      rst = 1'b1;
      req_valid0 = 1'b1; req_valid1 = 1'b1;
      req_op0 = OP_ADD;  req_op1 = OP_ADD;
      req_a0 = 32'd1; req_b0 = 32'd1; req_a1 = 32'd1; req_b1 = 32'd1;
      rsp_ready0 = 1'b0; rsp_ready1 = 1'b0;
      model_reset();
      #2;
      chk("reset_outputs", {60'd0, req_ready0, req_ready1, rsp_valid0, rsp_valid1, rsp_zero, rsp_err, 2'd0},
          68'd0);
      chk("reset_data", {36'd0, rsp_data}, 68'd0);
      @(negedge clk);
      rst = 1'b0;

      // Round robin with both requesters valid
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 1'b1, OP_SUB, 32'd9, 32'd9, OP_OR, 32'd1, 32'd2, 1'b1, 1'b1);
         chk("rr_grant", {66'd0, last_g0, last_g1}, (i % 2 == 0) ? 68'd2 : 68'd1);
         chk("rr_rsp", {33'd0, rsp_valid0, rsp_valid1, rsp_zero, rsp_data},
             (i % 2 == 0) ? {33'd0, 1'b1, 1'b0, 1'b1, 32'd0} : {33'd0, 1'b0, 1'b1, 1'b0, 32'd3});
      end
      idle(1'b1, 1'b1);

      // Single ADD from requester 0
      cycle(1'b1, 1'b0, OP_ADD, 32'd5, 32'd7, OP_AND, 32'd0, 32'd0, 1'b1, 1'b0);
      chk("add_grant", {67'd0, last_g0}, 68'd1);
      chk("add_rsp", {33'd0, rsp_valid0, rsp_err, rsp_zero, rsp_data}, {33'd0, 1'b1, 1'b0, 1'b0, 32'd12});
      idle(1'b1, 1'b0);

      // Owner 1 stalls the slot; requester 0 waits, then wins on the pop cycle
      cycle(1'b0, 1'b1, OP_AND, 32'd0, 32'd0, OP_ADD, 32'd1, 32'd2, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b0, OP_XOR, 32'd6, 32'd3, OP_AND, 32'd0, 32'd0, 1'b1, 1'b0);
         chk("stall_ready0", {67'd0, last_g0}, 68'd0);
         chk("stall_hold", {35'd0, rsp_valid1, rsp_data}, {35'd0, 1'b1, 32'd3});
      end
      cycle(1'b1, 1'b0, OP_XOR, 32'd6, 32'd3, OP_AND, 32'd0, 32'd0, 1'b0, 1'b1);
      chk("release_grant", {67'd0, last_g0}, 68'd1);
      chk("release_rsp", {35'd0, rsp_valid0, rsp_data}, {35'd0, 1'b1, 32'd5});
      idle(1'b1, 1'b0);

      // Illegal opcodes are consumed and flagged
      cycle(1'b0, 1'b1, OP_AND, 32'd0, 32'd0, 4'b1111, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b1);
      chk("illegal_rsp", {33'd0, rsp_valid1, rsp_err, rsp_zero, rsp_data}, {33'd0, 1'b1, 1'b1, 1'b1, 32'd0});
      cycle(1'b0, 1'b1, OP_AND, 32'd0, 32'd0, OP_NOR, 32'd0, 32'd0, 1'b1, 1'b1);
      chk("err_clear", {35'd0, rsp_err, rsp_data}, {35'd0, 1'b0, 32'hFFFF_FFFF});
      cycle(1'b1, 1'b0, 4'b0101, 32'd3, 32'd4, OP_AND, 32'd0, 32'd0, 1'b1, 1'b1);
      chk("illegal5_rsp", {35'd0, rsp_err, rsp_data}, {35'd0, 1'b1, 32'd0});
      idle(1'b1, 1'b1);

      // Shift and upper-immediate results
      cycle(1'b1, 1'b0, OP_SRA, 32'd4, 32'h8000_0000, OP_AND, 32'd0, 32'd0, 1'b1, 1'b0);
      chk("sra_rsp", {36'd0, rsp_data}, {36'd0, 32'hF800_0000});
      cycle(1'b0, 1'b1, OP_AND, 32'd0, 32'd0, OP_LUI, 32'd0, 32'h0000_1234, 1'b1, 1'b1);
      chk("lui_rsp", {36'd0, rsp_data}, {36'd0, 32'h1234_0000});
      idle(1'b1, 1'b1);

      // Random traffic against the scoreboard
      for (int i = 0; i < 60; i++) begin
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), $urandom, 32'($urandom_range(0, 40)),
               4'($urandom_range(0, 15)), $urandom, 32'($urandom_range(0, 40)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      idle(1'b1, 1'b1);

      // Asynchronous reset while a response is held
      cycle(1'b1, 1'b0, OP_ADD, 32'd1, 32'd1, OP_AND, 32'd0, 32'd0, 1'b0, 1'b0);
      chk("pre_reset_valid", {67'd0, rsp_valid0}, 68'd1);
      req_valid1 = 1'b1;
      rst = 1'b1;
      #1;
      chk("async_reset", {33'd0, rsp_valid0, rsp_valid1, req_ready0, req_ready1, rsp_data}, 68'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      cycle(1'b1, 1'b1, OP_ADD, 32'd2, 32'd2, OP_ADD, 32'd3, 32'd3, 1'b1, 1'b1);
      chk("post_reset_first", {66'd0, last_g0, last_g1}, 68'd2);
      cycle(1'b1, 1'b1, OP_ADD, 32'd2, 32'd2, OP_ADD, 32'd3, 32'd3, 1'b1, 1'b1);
      chk("post_reset_second", {66'd0, last_g0, last_g1}, 68'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
